// File: rtl/candidate_scan_sequencer.sv
// candidate_scan_sequencer
//   Sequences one error-correction job through the kmer/candidate extraction
//   pipeline: accepts a job, issues one kmer position per pipeline transfer,
//   counts returned results and pulses done once everything has drained.
//
// Ports
//   clk, rstb               clock, asynchronous active-low reset
//   job_valid / job_ready   job handshake (ready only while idle)
//   job_candidate           2-bit-per-base candidate, bit 0 = base -EXTENSION_WIDTH
//   job_start_pos/end_pos   signed first/last kmer position (inclusive)
//   job_direction           forwarded to pipeline
//   job_kmer_length         forwarded to pipeline
//   abort                   stop issuing, drain outstanding results, finish
//   pipe_ip_valid           issue strobe, transfer when pipe_ready4_ip is high
//   pipe_op_valid           one result returned by the pipeline
//   pipe_candidate/position/direction/kmer_length   latched job fields
//   busy, done              activity flag, one-cycle completion pulse
//   issued_count            positions accepted by the pipeline this job
//   returned_count          results counted this job
//   err_flags               {timeout, unexpected_result, range}, sticky per job
//
// Build option
//   CAND_SEQ_WATCHDOG_EN    enables the DRAIN watchdog (DRAIN_TIMEOUT cycles)
//                           and err_flags[2]; otherwise DRAIN waits forever.

module candidate_scan_sequencer #(
    parameter int MAX_READ_BIT_WIDTH = 8,
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int EXTENSION_WIDTH    = 5,
    parameter int MIN_KMER_WIDTH     = 12,
    parameter int DRAIN_TIMEOUT      = 64,
    localparam int CAND_W = 2 * (2**MAX_READ_BIT_WIDTH + 2*EXTENSION_WIDTH
                                 + 2**MAX_KMER_BIT_WIDTH - MIN_KMER_WIDTH),
    localparam int POS_W  = MAX_READ_BIT_WIDTH + 1,
    localparam int CNT_W  = MAX_READ_BIT_WIDTH + 2
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [CAND_W-1:0]             job_candidate,
    input  logic [POS_W-1:0]              job_start_pos,
    input  logic [POS_W-1:0]              job_end_pos,
    input  logic                          job_direction,
    input  logic [MAX_KMER_BIT_WIDTH-1:0] job_kmer_length,
    input  logic                          abort,
    output logic                          pipe_ip_valid,
    input  logic                          pipe_ready4_ip,
    input  logic                          pipe_op_valid,
    output logic [CAND_W-1:0]             pipe_candidate,
    output logic [POS_W-1:0]              pipe_position,
    output logic                          pipe_direction,
    output logic [MAX_KMER_BIT_WIDTH-1:0] pipe_kmer_length,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              issued_count,
    output logic [CNT_W-1:0]              returned_count,
    output logic [2:0]                    err_flags
);

    localparam logic signed [POS_W-1:0] POS_MIN = POS_W'(-EXTENSION_WIDTH);
    localparam logic signed [POS_W-1:0] POS_MAX =
        POS_W'(2**MAX_READ_BIT_WIDTH + EXTENSION_WIDTH - MIN_KMER_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [CAND_W-1:0]               cand_q, cand_d;
    logic [POS_W-1:0]                pos_q, pos_d;
    logic [POS_W-1:0]                end_q, end_d;
    logic                            dir_q, dir_d;
    logic [MAX_KMER_BIT_WIDTH-1:0]   klen_q, klen_d;
    logic [CNT_W-1:0]                issued_q, issued_d;
    logic [CNT_W-1:0]                returned_q, returned_d;
    logic [1:0]                      err_q, err_d;   // {unexpected_result, range}
    logic                            range_bad;

`ifdef CAND_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(DRAIN_TIMEOUT + 1);
    logic [WD_W-1:0]                 wd_q, wd_d;
    logic                            timeout_q, timeout_d;
`endif

    assign range_bad = ($signed(job_start_pos) < POS_MIN)
                    || ($signed(job_end_pos)   > POS_MAX)
                    || ($signed(job_start_pos) > $signed(job_end_pos));

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        pos_d         = pos_q;
        end_d         = end_q;
        dir_d         = dir_q;
        klen_d        = klen_q;
        issued_d      = issued_q;
        returned_d    = returned_q;
        err_d         = err_q;
        pipe_ip_valid = 1'b0;
        done          = 1'b0;
`ifdef CAND_SEQ_WATCHDOG_EN
        timeout_d     = timeout_q;
        wd_d          = (state_q == S_DRAIN) ? wd_q + WD_W'(1) : '0;
`endif

        // A result with nothing outstanding is flagged instead of counted.
        if (pipe_op_valid && (state_q == S_ISSUE || state_q == S_DRAIN)) begin
            if (returned_q == issued_q) err_d[1] = 1'b1;
            else                        returned_d = returned_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    cand_d     = job_candidate;
                    pos_d      = job_start_pos;
                    end_d      = job_end_pos;
                    dir_d      = job_direction;
                    klen_d     = job_kmer_length;
                    issued_d   = '0;
                    returned_d = '0;
                    err_d      = {1'b0, range_bad};
`ifdef CAND_SEQ_WATCHDOG_EN
                    timeout_d  = 1'b0;
`endif
                    // A rejected job passes through DRAIN with nothing
                    // outstanding, so it finishes exactly like an early abort.
                    state_d    = range_bad ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_DRAIN;
                end else begin
                    pipe_ip_valid = 1'b1;
                    if (pipe_ready4_ip) begin
                        issued_d = issued_q + CNT_W'(1);
                        if (pos_q == end_q) state_d = S_DRAIN;
                        else                pos_d   = pos_q + POS_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (returned_d == issued_q) begin
                    state_d = S_DONE;
                end
`ifdef CAND_SEQ_WATCHDOG_EN
                else if (wd_q == WD_W'(DRAIN_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
`endif
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            cand_q     <= '0;
            pos_q      <= '0;
            end_q      <= '0;
            dir_q      <= 1'b0;
            klen_q     <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            err_q      <= '0;
`ifdef CAND_SEQ_WATCHDOG_EN
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            pos_q      <= pos_d;
            end_q      <= end_d;
            dir_q      <= dir_d;
            klen_q     <= klen_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            err_q      <= err_d;
`ifdef CAND_SEQ_WATCHDOG_EN
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign job_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign pipe_candidate   = cand_q;
    assign pipe_position    = pos_q;
    assign pipe_direction   = dir_q;
    assign pipe_kmer_length = klen_q;
    assign issued_count     = issued_q;
    assign returned_count   = returned_q;
`ifdef CAND_SEQ_WATCHDOG_EN
    assign err_flags        = {timeout_q, err_q};
`else
    assign err_flags        = {1'b0, err_q};
`endif

endmodule

// File: tb/tb_candidate_scan_sequencer.sv
module tb_candidate_scan_sequencer;

    localparam int CAND_W = 636;
    localparam int POS_W  = 9;
    localparam int CNT_W  = 10;
    localparam int KW     = 6;

    logic              clk;
    logic              rstb;
    logic              job_valid;
    logic              job_ready;
    logic [CAND_W-1:0] job_candidate;
    logic [POS_W-1:0]  job_start_pos;
    logic [POS_W-1:0]  job_end_pos;
    logic              job_direction;
    logic [KW-1:0]     job_kmer_length;
    logic              abort;
    logic              pipe_ip_valid;
    logic              pipe_ready4_ip;
    logic              pipe_op_valid;
    logic [CAND_W-1:0] pipe_candidate;
    logic [POS_W-1:0]  pipe_position;
    logic              pipe_direction;
    logic [KW-1:0]     pipe_kmer_length;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  issued_count;
    logic [CNT_W-1:0]  returned_count;
    logic [2:0]        err_flags;

    candidate_scan_sequencer #(
        .MAX_READ_BIT_WIDTH (8),
        .MAX_KMER_BIT_WIDTH (6),
        .EXTENSION_WIDTH    (5),
        .MIN_KMER_WIDTH     (12),
        .DRAIN_TIMEOUT      (8)
    ) dut (
        .clk              (clk),
        .rstb             (rstb),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_candidate    (job_candidate),
        .job_start_pos    (job_start_pos),
        .job_end_pos      (job_end_pos),
        .job_direction    (job_direction),
        .job_kmer_length  (job_kmer_length),
        .abort            (abort),
        .pipe_ip_valid    (pipe_ip_valid),
        .pipe_ready4_ip   (pipe_ready4_ip),
        .pipe_op_valid    (pipe_op_valid),
        .pipe_candidate   (pipe_candidate),
        .pipe_position    (pipe_position),
        .pipe_direction   (pipe_direction),
        .pipe_kmer_length (pipe_kmer_length),
        .busy             (busy),
        .done             (done),
        .issued_count     (issued_count),
        .returned_count   (returned_count),
        .err_flags        (err_flags)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-stage pipeline stand-in: each transfer returns one result 2 cycles later.
    logic s1, s2, pipe_en, inj;
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pipe_ip_valid & pipe_ready4_ip;
            s2 <= s1;
        end
    end
    assign pipe_op_valid = (s2 & pipe_en) | inj;

    // Scoreboard of expected issue positions plus the latched job fields.
    int                queue_pos[$];
    logic [CAND_W-1:0] exp_cand;
    logic              exp_dir;
    logic [KW-1:0]     exp_klen;
    int xfer_cnt = 0, done_cnt = 0;
    int last_xfer_cyc = 0, done_cyc = 0, acc_cyc = 0;
    bit done_seen = 0;

    always @(negedge clk) begin
        if (rstb) begin
            if (job_valid && job_ready) acc_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_seen = 1;
            end
            if (pipe_ip_valid && pipe_ready4_ip) begin
                xfer_cnt++;
                last_xfer_cyc = cyc;
                checks++;
                if (queue_pos.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected pos=%0d with empty scoreboard",
                             $signed(pipe_position));
                end else begin
                    int e;
                    e = queue_pos.pop_front();
                    if (int'($signed(pipe_position)) !== e
                        || pipe_candidate !== exp_cand
                        || pipe_direction !== exp_dir
                        || pipe_kmer_length !== exp_klen) begin
                        errors++;
                        $display("FAIL issue_fields pos=%0d exp %0d dir=%b exp %b klen=%0d exp %0d cand_ok=%b",
                                 $signed(pipe_position), e, pipe_direction, exp_dir,
                                 pipe_kmer_length, exp_klen, pipe_candidate === exp_cand);
                    end
                end
            end
        end
    end

    task automatic load_job(input int s, input int e);
        logic [CAND_W-1:0] c;
        for (int i = 0; i < CAND_W; i++) c[i] = 1'($urandom_range(0, 1));
        exp_cand = c;
        exp_dir  = 1'($urandom_range(0, 1));
        exp_klen = KW'($urandom_range(12, 63));
        if (s >= -5 && e <= 249 && s <= e)
            for (int p = s; p <= e; p++) queue_pos.push_back(p);
        job_candidate   = c;
        job_start_pos   = POS_W'(s);
        job_end_pos     = POS_W'(e);
        job_direction   = exp_dir;
        job_kmer_length = exp_klen;
        job_valid       = 1'b1;
        done_seen       = 0;
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    // n counts cycles after the accepting edge (n=0 is the first ISSUE cycle).
    task automatic do_job(input int s, input int e, input bit alt_ready,
                          input int abort_n, input int inj_n, input int budget,
                          input bit expect_done);
        int n;
        load_job(s, e);
        n = 0;
        while (!done_seen && n < budget) begin
            pipe_ready4_ip = alt_ready ? ((n % 2) == 1) : 1'b1;
            abort          = (n == abort_n);
            inj            = (n == inj_n);
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b0; inj = 1'b0; pipe_ready4_ip = 1'b1;
        if (expect_done) begin
            checks++;
            if (!done_seen) begin
                errors++;
                $display("FAIL done_timeout start=%0d end=%0d no done within %0d cycles", s, e, budget);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0; #1;
        chk("reset_job_ready", int'(job_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ip_valid", int'(pipe_ip_valid), 0);
        chk("reset_issued", int'(issued_count), 0);
        chk("reset_returned", int'(returned_count), 0);
        chk("reset_err", int'(err_flags), 0);
        chk("reset_position", int'(pipe_position), 0);
        chk("reset_cand_zero", int'(pipe_candidate == '0), 1);
        @(posedge clk); #1; rstb = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_scan();
        int x0, d0;
        x0 = xfer_cnt; d0 = done_cnt;
        do_job(-5, 3, 1'b0, -1, -1, 60, 1'b1);
        chk("scan_xfers", xfer_cnt - x0, 9);
        chk("scan_done_latency", done_cyc - last_xfer_cyc, 3);
        chk("scan_issued", int'(issued_count), 9);
        chk("scan_returned", int'(returned_count), 9);
        chk("scan_err", int'(err_flags), 0);
        chk("scan_done_count", done_cnt - d0, 1);
        chk("scan_sb_empty", queue_pos.size(), 0);
    endtask

    task automatic test_alt_ready();
        int d0;
        d0 = done_cnt;
        do_job(10, 12, 1'b1, -1, -1, 60, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("alt_issued", int'(issued_count), 3);
        chk("alt_returned", int'(returned_count), 3);
        chk("alt_done_once", done_cnt - d0, 1);
        chk("alt_pos_hold", int'($signed(pipe_position)), 12);
        chk("alt_sb_empty", queue_pos.size(), 0);
    endtask

    task automatic test_abort();
        do_job(0, 100, 1'b0, 3, -1, 60, 1'b1);
        chk("abort_issued", int'(issued_count), 3);
        chk("abort_returned", int'(returned_count), 3);
        chk("abort_err", int'(err_flags), 0);
        chk("abort_sb_left", queue_pos.size(), 98);
        queue_pos.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_range();
        int s_t[5] = '{20, -6, 240, -5, 249};
        int e_t[5] = '{10,  0, 250, -5, 249};
        bit ok_t[5] = '{0, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            int x0;
            x0 = xfer_cnt;
            do_job(s_t[i], e_t[i], 1'b0, -1, -1, 40, 1'b1);
            if (ok_t[i]) begin
                chk("range_ok_err", int'(err_flags), 0);
                chk("range_ok_xfers", xfer_cnt - x0, 1);
                chk("range_ok_latency", done_cyc - last_xfer_cyc, 3);
            end else begin
                chk("range_bad_err", int'(err_flags), 1);
                chk("range_bad_xfers", xfer_cnt - x0, 0);
                chk("range_bad_latency", done_cyc - acc_cyc, 2);
                chk("range_bad_issued", int'(issued_count), 0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unexpected();
        // Abort before any issue, then a stray result while draining.
        do_job(5, 6, 1'b0, 0, 1, 20, 1'b1);
        chk("unexp_err", int'(err_flags), 3'b010);
        chk("unexp_returned", int'(returned_count), 0);
        chk("unexp_issued", int'(issued_count), 0);
        queue_pos.delete();
        inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        chk("idle_ret_ignored", int'(returned_count), 0);
        chk("idle_err_sticky", int'(err_flags), 3'b010);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midjob();
        load_job(0, 50);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy_before", int'(busy), 1);
        #2 rstb = 1'b0;
        #1;
        chk("mid_busy", int'(busy), 0);
        chk("mid_ready", int'(job_ready), 1);
        chk("mid_issued", int'(issued_count), 0);
        chk("mid_ip_valid", int'(pipe_ip_valid), 0);
        chk("mid_position", int'(pipe_position), 0);
        queue_pos.delete();
        @(posedge clk); #1; rstb = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_drain_wait();
        pipe_en = 1'b0;
`ifdef CAND_SEQ_WATCHDOG_EN
        do_job(0, 0, 1'b0, -1, -1, 40, 1'b1);
        chk("wd_latency", done_cyc - (last_xfer_cyc + 1), 9);
        chk("wd_err", int'(err_flags), 3'b100);
        chk("wd_issued", int'(issued_count), 1);
        chk("wd_returned", int'(returned_count), 0);
`else
        do_job(0, 0, 1'b0, -1, -1, 30, 1'b0);
        chk("nowd_no_done", int'(done_seen), 0);
        chk("nowd_busy", int'(busy), 1);
        chk("nowd_err", int'(err_flags), 0);
        chk("nowd_issued", int'(issued_count), 1);
        rstb = 1'b0; #1;
        chk("nowd_reset_idle", int'(busy), 0);
        @(posedge clk); #1; rstb = 1'b1;
`endif
        pipe_en = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        job_valid       = 1'b0;
        job_candidate   = '0;
        job_start_pos   = '0;
        job_end_pos     = '0;
        job_direction   = 1'b0;
        job_kmer_length = '0;
        abort           = 1'b0;
        pipe_ready4_ip  = 1'b1;
        pipe_en         = 1'b1;
        inj             = 1'b0;
        test_reset();
        test_full_scan();
        test_alt_ready();
        test_abort();
        test_range();
        test_unexpected();
        test_reset_midjob();
        test_drain_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
